rv32_dmem_responder: RTL

//  Data-memory responder (slave) for the RV32I core's load/store port.

---
 rtl/rv32_dmem_responder_if.sv | 26 ++
 rtl/rv32_dmem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rv32_dmem_responder_if.sv
// Load/store port bundle between the core (master) and the data-memory
// responder (slave): request handshake, request payload, response handshake.
interface rv32_dmem_responder_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic [3:0]  i_req_be;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
        input  i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_be,
        output i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/rv32_dmem_responder.sv
// Data-memory responder for the RV32I load/store port: one request at a
// time, byte-enabled word store or word load, WAIT_STATES cycles of latency.
// Ports: i_clk, i_rst (async, active-low), bus (rv32_dmem_responder_if.slave).
// Optional: define DMEM_MISALIGN_CHECK_EN to fault illegal addr/be pairs.
module rv32_dmem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    rv32_dmem_responder_if.slave  bus
);

    localparam int          DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [0:DEPTH-1];

    logic [31:0]           off;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  in_range;
    logic                  legal;
    logic                  ok;
    logic                  wr_en;

    // Subtraction is only meaningful when addr >= BASE_ADDR; the 33-bit
    // compare keeps the span test exact even for very wide RAMs.
    assign off      = addr_q - BASE_ADDR;
    assign idx      = off[ADDR_WIDTH+1:2];
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, off} < SPAN);

`ifdef DMEM_MISALIGN_CHECK_EN
    always_comb begin
        legal = 1'b0;
        if (be_q == (4'b0001 << addr_q[1:0]))
            legal = 1'b1;
        if (be_q == 4'b0011 && addr_q[1:0] == 2'b00)
            legal = 1'b1;
        if (be_q == 4'b1100 && addr_q[1:0] == 2'b10)
            legal = 1'b1;
        if (be_q == 4'b1111 && addr_q[1:0] == 2'b00)
            legal = 1'b1;
    end
`else
    assign legal = 1'b1;
`endif

    assign ok = in_range && legal;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wr_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_req_valid) begin
                    we_d        = bus.i_req_we;
                    addr_d      = bus.i_req_addr;
                    wdata_d     = bus.i_req_wdata;
                    be_d        = bus.i_req_be;
                    cnt_d       = 4'(WAIT_STATES);
                    req_ready_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    wr_en       = ok && we_q;
                    rdata_d     = (ok && !we_q) ? mem[idx] : 32'h0;
                    err_d       = !ok;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rdata_d     = 32'h0;
                    err_d       = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                rdata_d     = 32'h0;
                err_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // RAM is never cleared; a reset drops the FSM out of WAIT so a pending
    // store simply never reaches this block.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (be_q[k])
                    mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
        end
    end

    assign bus.o_req_ready = req_ready_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rdata_q;
    assign bus.o_rsp_err   = err_q;

endmodule
